// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the two-digit BCD game countdown timer.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    // Values above 99 are clamped so the digits can never leave 0..9.
    function automatic bcd_pair_t to_bcd(input int unsigned value);
        bcd_pair_t   r;
        int unsigned v;
        v      = (value > 99) ? 99 : value;
        r.tens = bcd_t'(v / 10);
        r.ones = bcd_t'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_down_counter_2d.sv
// Two-digit BCD down counter with synchronous load; stops at 00.
module bcd_down_counter_2d
    import game_timer_pkg::*;
#(
    parameter bcd_pair_t RESET_VAL = '0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      load_i,
    input  bcd_pair_t load_val_i,
    input  logic      dec_i,
    output bcd_t      tens_o,
    output bcd_t      ones_o,
    output logic      is_zero_next_o
);

    bcd_t tens_q, tens_d;
    bcd_t ones_q, ones_d;
    logic is_zero;

    assign is_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load_i) begin
            tens_d = load_val_i.tens;
            ones_d = load_val_i.ones;
        end else if (dec_i && !is_zero) begin
            // Borrow from tens when ones wraps 0 -> 9.
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tens_q <= RESET_VAL.tens;
            ones_q <= RESET_VAL.ones;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o         = tens_q;
    assign ones_o         = ones_q;
    assign is_zero_next_o = (tens_q == 4'd0) && (ones_q == 4'd1);

endmodule

// File: rtl/game_countdown_timer.sv
// Game-loop seconds countdown: divider ticks accumulate into seconds, which
// decrement a BCD pair until 00, then a one-cycle expiry pulse is raised.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SECOND = 10,
    parameter int unsigned START_SECONDS    = 60
) (
    input  logic   i_Clk,
    input  logic   i_Rst_L,
    input  logic   i_Tick,
    input  logic   i_Start,
    input  logic   i_Pause,
    output bcd_t   o_Tens,
    output bcd_t   o_Ones,
    output logic   o_Running,
    output logic   o_Expired,
    output logic   o_Done,
    output state_e o_Dbg_State
);

    localparam int unsigned TICK_W =
        (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICKS_PER_SECOND - 1);
    localparam bcd_pair_t         START_BCD = to_bcd(START_SECONDS);

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              running_q, running_d;
    logic              expired_q, expired_d;
    logic              done_q, done_d;

    logic ctr_load;
    logic ctr_dec;
    logic ctr_zero_next;

    bcd_down_counter_2d #(
        .RESET_VAL (START_BCD)
    ) u_digits (
        .clk_i          (i_Clk),
        .rst_ni         (i_Rst_L),
        .load_i         (ctr_load),
        .load_val_i     (START_BCD),
        .dec_i          (ctr_dec),
        .tens_o         (o_Tens),
        .ones_o         (o_Ones),
        .is_zero_next_o (ctr_zero_next)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        expired_d  = 1'b0;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;

        if (i_Start) begin
            ctr_load   = 1'b1;
            tick_cnt_d = '0;
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    // Tick is counted before a same-cycle pause; expiry overrides the pause.
                    if (i_Pause) begin
                        state_d = ST_PAUSE;
                    end
                    if (i_Tick) begin
                        if (tick_cnt_q == TICK_MAX) begin
                            tick_cnt_d = '0;
                            ctr_dec    = 1'b1;
                            if (ctr_zero_next) begin
                                state_d   = ST_EXPIRED;
                                expired_d = 1'b1;
                            end
                        end else begin
                            tick_cnt_d = tick_cnt_q + TICK_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_Pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end

        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            running_q  <= running_d;
            expired_q  <= expired_d;
            done_q     <= done_d;
        end
    end

    assign o_Running   = running_q;
    assign o_Expired   = expired_q;
    assign o_Done      = done_q;
    assign o_Dbg_State = state_q;

endmodule
